// File: rtl/fpga_scff_bist_pkg.sv
// Shared types and constants for the scan-chain self-test engine.
package fpga_scff_bist_pkg;

  // Test sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_INJECT = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_POST   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Error counter saturation value
  localparam logic [7:0] ERR_SAT = 8'hFF;

  // Saturating increment of the 8-bit error counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == ERR_SAT) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpga_scff_bist_if.sv
// Control/status and scan-chain signals of the self-test engine.
// The slave modport is the engine; the master modport is the SoC/fabric side.
interface fpga_scff_bist_if #(
  parameter int CNT_W = 12
);
  logic             start;
  logic             abort;
  logic             sc_tail;
  logic             sc_head;
  logic             Test_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_count;
  logic [CNT_W-1:0] hit_index;

  modport slave (
    input  start, abort, sc_tail,
    output sc_head, Test_en, busy, done, pass, err_count, hit_index
  );

  modport master (
    output start, abort, sc_tail,
    input  sc_head, Test_en, busy, done, pass, err_count, hit_index
  );
endinterface

// File: rtl/fpga_scff_bist_checker.sv
// Tail-side checker: shared sample counter, expected-value compare,
// saturating error count and first-hit index latch.
module scff_tail_checker
  import fpga_scff_bist_pkg::*;
#(
  parameter int CHAIN_LEN   = 2304,
  parameter int POST_CYCLES = 2,
  parameter int CNT_W       = $clog2(CHAIN_LEN + POST_CYCLES + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_clr_i,   // accepted start: clear results
  input  logic             cnt_clr_i,   // reload counter to 0
  input  logic             cnt_inc_i,   // advance counter
  input  logic             chk_en_i,    // this edge is a checked sample
  input  logic             sc_tail_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [7:0]       err_count_o,
  output logic [CNT_W-1:0] hit_index_o
);

  // The pulse must reach the tail on this sample index
  localparam logic [CNT_W-1:0] HIT_IDX = CNT_W'(CHAIN_LEN + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       err_q, err_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] sample_idx_s;
  logic             expect_s;
  logic             mismatch_s;

  // Next-state for counter and results; the counter holds s-1 at sample edges
  always_comb begin
    sample_idx_s = cnt_q + CNT_W'(1);
    expect_s     = (sample_idx_s == HIT_IDX);
    // !== so that X/Z on the tail also counts as an error in simulation
    mismatch_s   = (sc_tail_i !== expect_s);
    cnt_d        = cnt_q;
    err_d        = err_q;
    hit_d        = hit_q;

    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_inc_i) begin
      cnt_d = sample_idx_s;
    end else begin
      cnt_d = cnt_q;
    end

    if (res_clr_i) begin
      err_d = 8'd0;
      hit_d = '0;
    end else if (chk_en_i) begin
      if (mismatch_s) begin
        err_d = sat_inc(err_q);
      end else begin
        err_d = err_q;
      end
      // Only the first '1' is latched; index 0 means never seen
      if ((sc_tail_i === 1'b1) && (hit_q == '0)) begin
        hit_d = sample_idx_s;
      end else begin
        hit_d = hit_q;
      end
    end else begin
      err_d = err_q;
      hit_d = hit_q;
    end
  end

  // Counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 8'd0;
      hit_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      hit_q <= hit_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign err_count_o = err_q;
  assign hit_index_o = hit_q;

endmodule

// File: rtl/fpga_scff_bist.sv
// Scan-chain self-test engine: flushes the chain, injects a single '1' at the
// head and checks it leaves the tail exactly CHAIN_LEN+1 samples later.
module fpga_scff_bist
  import fpga_scff_bist_pkg::*;
#(
  parameter int CHAIN_LEN   = 2304,
  parameter int POST_CYCLES = 2
) (
  input  logic clk,
  input  logic greset_n,
  fpga_scff_bist_if.slave bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + POST_CYCLES + 2);

  // Counter values on the last edge of each phase (counter = s-1 once shifting)
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(CHAIN_LEN + POST_CYCLES);

  state_e           state_q;
  logic             sc_head_q;
  logic             test_en_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic             accept_start_s;
  logic             abort_s;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic             chk_en_s;
  logic [CNT_W-1:0] cnt_s;
  logic [7:0]       err_count_s;
  logic [CNT_W-1:0] hit_index_s;

  // Counter/checker strobes derived from the current state
  always_comb begin
    accept_start_s = (state_q == ST_IDLE) && bus.start;
    // start wins over abort when idle, so abort only acts outside IDLE
    abort_s        = (state_q != ST_IDLE) && bus.abort;
    cnt_clr_s      = 1'b0;
    cnt_inc_s      = 1'b0;
    chk_en_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr_s = accept_start_s;
      end
      ST_FLUSH: begin
        if (abort_s) begin
          cnt_clr_s = 1'b0;
        end else if (cnt_s == FLUSH_LAST) begin
          cnt_clr_s = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_INJECT, ST_SHIFT, ST_POST: begin
        cnt_inc_s = !abort_s;
        chk_en_s  = !abort_s;
      end
      default: begin
        cnt_clr_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered head, scan-enable and status outputs
  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      state_q   <= ST_IDLE;
      sc_head_q <= 1'b0;
      test_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else if (abort_s) begin
      state_q   <= ST_IDLE;
      sc_head_q <= 1'b0;
      test_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b1;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_FLUSH;
            sc_head_q <= 1'b0;
            test_en_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (cnt_s == FLUSH_LAST) begin
            state_q   <= ST_INJECT;
            sc_head_q <= 1'b1;
          end
        end
        ST_INJECT: begin
          state_q   <= ST_SHIFT;
          sc_head_q <= 1'b0;
        end
        ST_SHIFT: begin
          if (cnt_s == SHIFT_LAST) begin
            state_q <= ST_POST;
          end
        end
        ST_POST: begin
          if (cnt_s == POST_LAST) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          test_en_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          pass_q    <= (err_count_s == 8'd0);
        end
        default: begin
          state_q   <= ST_IDLE;
          sc_head_q <= 1'b0;
          test_en_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  scff_tail_checker #(
    .CHAIN_LEN   (CHAIN_LEN),
    .POST_CYCLES (POST_CYCLES),
    .CNT_W       (CNT_W)
  ) u_checker (
    .clk         (clk),
    .rst_n       (greset_n),
    .res_clr_i   (accept_start_s),
    .cnt_clr_i   (cnt_clr_s),
    .cnt_inc_i   (cnt_inc_s),
    .chk_en_i    (chk_en_s),
    .sc_tail_i   (bus.sc_tail),
    .cnt_o       (cnt_s),
    .err_count_o (err_count_s),
    .hit_index_o (hit_index_s)
  );

  assign bus.sc_head   = sc_head_q;
  assign bus.Test_en   = test_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_s;
  assign bus.hit_index = hit_index_s;

endmodule
